uart_rx_buffer: RTL
===================

Name: uart_rx_buffer

Overview:
System-clock-domain consumer of the UART receiver's byte output (`rx_data`, `rx_status`). It synchronises the receiver's one-sample-clock `rx_status` pulse into `clk` and queues received bytes in a small FIFO. It exposes two CPU-bus registers, RXD and CON; CON bit3 is the sticky received-event flag. It also drives a level interrupt to the CPU.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2. Ignored when UART_RX_FIFO_EN is undefined.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; must be at least 4x the receiver's sample clock.
- reset  in  1  reset.
- rx_data  in  8  received byte from the receiver; stable at least 15 sample clocks before and after `rx_status`.
- rx_status  in  1  byte-done pulse from the receiver, asynchronous to `clk`.
- bus_rd  in  1  CPU read strobe, one clk per access.
- bus_wr  in  1  CPU write strobe, one clk per access.
- bus_addr  in  1  register select: 0 = RXD, 1 = CON.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, registered.
- irq  out  1  level interrupt, active high.

Behaviour:
- Interface: reset `reset`, asynchronous, active-high; clock `clk`.
- Reset values:
  - `bus_rdata` = 0, `irq` = 0.
  - FIFO empty; pointers and count = 0.
  - CON bits all 0; synchroniser flops all 0.
- Synchroniser:
  - `rx_status` passes through s1 -> s2 -> s3.
  - push = s2 & ~s3. Exactly one push per pulse, however many clk cycles the pulse spans.
  - On push, `rx_data` is sampled directly. This is multi-bit CDC safe because `rx_data` is stable around the pulse.
  - A written byte is visible (CON.rx_ready = 1) on the 3rd clk edge after `rx_status` is first sampled high.
- FIFO:
  - Write pointer, read pointer and count, each with AW+1 bits of width for count.
  - Pointers wrap modulo DEPTH.
  - Full when count = DEPTH; empty when count = 0.
- Pop: `bus_rd` with `bus_addr` = 0.
  - Next cycle, `bus_rdata` = {24'b0, head byte}; the read pointer advances on the strobe edge.
  - Pop while empty: `bus_rdata` = 0, no pointer change, no error.
- Push while full:
  - No pop in the same cycle: byte dropped, CON.overrun set, contents unchanged.
  - Pop in the same cycle: pop and push both occur, count unchanged, no overrun.
- Push and pop when not full: both occur, count unchanged.
- CON register (reads as {28'b0, bit3..bit0}):
  - bit0 irq_en: read/write.
  - bit1 rx_ready: read-only, = ~empty.
  - bit2 overrun: write-1-to-clear. A set in the same cycle as a clear wins.
  - bit3 rx_event: set on every push, including dropped bytes. Cleared by a CON read; a set in the same cycle as the clear wins.
  - Reading CON returns the values before the clear.
- `irq` = registered (irq_en & ~empty) | (irq_en & overrun); updates one cycle after the cause.
- Bus writes to RXD are ignored. Simultaneous `bus_rd` and `bus_wr`: both act, and the read returns pre-write values.
- Reset mid-operation, including mid-pulse: all state clears. A pulse already high at reset release produces one push once s2 rises.

Optional Feature:
UART_RX_FIFO_EN
- Defined: DEPTH-entry FIFO as described.
- Undefined: a single holding register with DEPTH treated as 1.
  - Full = holding valid.
  - Push while valid and not simultaneously popped -> drop + overrun.
  - Push with a simultaneous pop replaces the held byte.
  - Register map and timing are identical.

Decomposition:
- Package `uart_pkg` holds:
  - register indices: RXD_IDX = 0, CON_IDX = 1;
  - CON bit positions: CON_IRQEN = 0, CON_READY = 1, CON_OVR = 2, CON_EVT = 3;
  - a byte typedef `uart_byte_t` (8 bits).
- Sub-module `sync_pulse`: 3-flop synchroniser plus rising-edge detector, output `push`, reset to 0. It is reused by the transmit side for tx-done.

Test Plan:
1. Single byte: `rx_data` = 0xA5 with a 16-clk `rx_status` pulse -> rx_ready = 1 exactly 3 clk later; RXD read -> `bus_rdata` = 0x000000A5; CON read -> 0x8, then 0x0.
2. Fill to overrun:
   - With UART_RX_FIFO_EN and DEPTH = 4, push 0x01..0x05 with no reads -> CON = 0xE.
   - Reads return 0x01..0x04; a 5th read returns 0.
   - Write CON = 0x4 -> overrun clears.
3. Full plus simultaneous pop: FIFO full, push 0x77 in the same clk as an RXD read -> no overrun, count stays 4, 0x77 is the last byte out.
4. Interrupt: write CON = 0x1 with the FIFO empty -> `irq` = 0; push 0x3C -> `irq` = 1; read RXD -> `irq` = 0 one clk after the pop.
5. Reset mid-operation: assert `reset` with 2 bytes queued and a pulse active -> all outputs 0, FIFO empty; the pulse still high at release yields one push.
6. Without UART_RX_FIFO_EN: push 0x11 then 0x22 with no read -> RXD = 0x11, overrun = 1, and a second RXD read returns 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: register indices, CON bit
// positions and the byte type carried between receiver and buffer.
package uart_pkg;

  // Register select values on bus_addr.
  localparam int RXD_IDX = 0;
  localparam int CON_IDX = 1;

  // CON register bit positions.
  localparam int CON_IRQEN = 0;
  localparam int CON_READY = 1;
  localparam int CON_OVR   = 2;
  localparam int CON_EVT   = 3;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_buffer_sync_pulse.sv
// sync_pulse: three-flop synchroniser for a slow asynchronous pulse plus a
// rising-edge detector. Emits exactly one clk-wide push per input pulse,
// however long the pulse is. Shared with the transmit side (tx-done).
module sync_pulse (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic push
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Shift the asynchronous level down the chain; s1 may go metastable.
  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser flops, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign push = s2_q & ~s3_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: clk-domain consumer of the UART receiver output. Queues
// received bytes and exposes RXD (pop) and CON (irq_en, rx_ready, overrun,
// rx_event) registers plus a level interrupt.
// Build option: UART_RX_FIFO_EN selects a DEPTH-entry FIFO; when undefined
// a single holding register is used instead, with the same register map.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic        bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  logic       push;
  logic       pop_req, con_rd, con_wr;
  logic       empty, full, pop, push_ok, drop;
  uart_byte_t head;

  sync_pulse u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (rx_status),
    .push     (push)
  );

  assign pop_req = bus_rd & (bus_addr == 1'(RXD_IDX));
  assign con_rd  = bus_rd & (bus_addr == 1'(CON_IDX));
  assign con_wr  = bus_wr & (bus_addr == 1'(CON_IDX));
  assign pop     = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so only a full, unpopped
  // buffer drops the incoming byte.
  assign drop    = push & full & ~pop;
  assign push_ok = push & ~drop;

  // Only the CON control bits of the write data are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^{bus_wdata[31:3], bus_wdata[1]};

`ifdef UART_RX_FIFO_EN
  uart_byte_t    mem_q [DEPTH];
  uart_byte_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // FIFO next state: pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  // FIFO storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  // Single holding register: the buffer depth collapses to one entry.
  localparam int HOLD_DEPTH = (DEPTH > 0) ? 1 : 1;

  uart_byte_t hold_q, hold_d;
  logic       valid_q, valid_d;
  logic [AW:0] count_w;

  assign count_w = {{AW{1'b0}}, valid_q};
  assign empty   = ~valid_q;
  assign full    = (count_w == (AW+1)'(HOLD_DEPTH));
  assign head    = hold_q;

  // Holding register next state: a push with a pop replaces the byte.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (pop) valid_d = 1'b0;
    if (push_ok) begin
      hold_d  = rx_data;
      valid_d = 1'b1;
    end
  end

  // Holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end
`endif

  logic        irq_en_q, irq_en_d;
  logic        ovr_q, ovr_d;
  logic        evt_q, evt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic [3:0]  con_val;

  // CON bits, read data and interrupt. Sets beat same-cycle clears, and
  // reads always return the pre-edge (pre-write, pre-clear) state.
  always_comb begin
    con_val            = '0;
    con_val[CON_IRQEN] = irq_en_q;
    con_val[CON_READY] = ~empty;
    con_val[CON_OVR]   = ovr_q;
    con_val[CON_EVT]   = evt_q;

    irq_en_d = irq_en_q;
    ovr_d    = ovr_q;
    evt_d    = evt_q;
    rdata_d  = rdata_q;

    if (pop_req) rdata_d = empty ? 32'h0 : {24'h0, head};
    if (con_rd)  rdata_d = {28'h0, con_val};

    if (con_wr) begin
      irq_en_d = bus_wdata[CON_IRQEN];
      if (bus_wdata[CON_OVR]) ovr_d = 1'b0;
    end
    if (drop) ovr_d = 1'b1;

    if (con_rd) evt_d = 1'b0;
    if (push)   evt_d = 1'b1;

    irq_d = (irq_en_q & ~empty) | (irq_en_q & ovr_q);
  end

  // Control/status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      ovr_q    <= 1'b0;
      evt_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      ovr_q    <= ovr_d;
      evt_q    <= evt_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq       = irq_q;

endmodule
